uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the team's fixed 8-bit, one-bit-per-clock UART TX.
- Adds a programmable baud divider, configurable data width, and optional parity with even/odd selection.
- Adds 1 or 2 stop bits and a small TX FIFO so software or the bench can queue several characters.
- Sits between the register/stimulus side (tx_start/data_in) and the serial line (tx).

Parameters:
DATA_W, 8, data bits per frame (5..9).
CLKS_PER_BIT, 16, clock cycles each serial bit is held (>=2).
FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
tx_start  input  1  write strobe; pushes data_in into the FIFO when not full.
data_in  input  DATA_W  character to queue.
parity_en  input  1  1 = insert parity bit after data.
even_parity  input  1  1 = even parity, 0 = odd parity.
two_stop  input  1  1 = two stop bits, 0 = one.
tx  output  1  serial line, idles high.
tx_busy  output  1  1 while the FSM is not in IDLE.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  output  1  FIFO holds zero entries.
fifo_level  output  $clog2(FIFO_DEPTH+1)  current entry count.
overflow  output  1  one-cycle pulse: tx_start while fifo_full, data dropped.

Behaviour:
- Reset (async, any time including mid-frame):
  - tx=1, tx_busy=0, overflow=0.
  - FIFO flushed: level=0, empty=1, full=0.
  - FSM returns to IDLE; baud and bit counters cleared.
- FIFO write:
  - tx_start=1 and fifo_full=0 at a rising edge: data_in stored, level+1.
  - tx_start=1 and fifo_full=1: write dropped, overflow=1 for the next cycle only.
  - Full is evaluated on the registered value. A same-edge pop does not make room for that write.
- Pop and start:
  - FSM in IDLE with fifo_empty=0 at an edge: pop head entry, latch parity_en/even_parity/two_stop, register tx=0, enter START.
  - Latency: write at edge k -> tx falls after edge k+1.
  - Simultaneous write and pop: level unchanged, both take effect.
  - Config changes mid-frame have no effect until the next pop.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: DATA_W bits, LSB first.
  - PARITY: only if the latched parity_en=1.
  - STOP: 1 bit, or 2 if latched two_stop=1; tx=1.
- Bit timing:
  - Each bit, including each stop bit, holds tx for exactly CLKS_PER_BIT cycles, counted by the baud counter 0..CLKS_PER_BIT-1.
  - State and bit advance when the counter reaches CLKS_PER_BIT-1.
- Parity bit:
  - Even: parity = XOR of data bits (total ones incl. parity is even).
  - Odd: inverted.
- Frame length: (1 + DATA_W + parity_en + 1 + two_stop) * CLKS_PER_BIT cycles.
- End of last stop bit:
  - FIFO non-empty: pop immediately and go to START with zero idle cycles between frames (back-to-back).
  - FIFO empty: go to IDLE, tx stays 1, tx_busy falls.
- tx_busy = (state != IDLE), registered together with state.

Test Plan:
1. Reset then idle 50 cycles -> tx=1, tx_busy=0, fifo_empty=1, fifo_level=0 throughout.
2. DATA_W=8, CLKS_PER_BIT=4, parity_en=1, even_parity=1, two_stop=0, write 0xA5 -> tx falls one edge after the write. Serial bits 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles total). tx_busy then drops.
3. Same data with even_parity=0, two_stop=1 -> parity bit=1, then two stop bits. Frame is 48 cycles.
4. Write 0x31, 0x32, 0x33 on consecutive cycles, parity off -> fifo_level peaks at 2 (first entry popped on the next edge). Three 40-cycle frames follow back-to-back with no idle cycle. tx_busy stays high for 120 cycles.
5. Fill FIFO (4 writes while tx busy), then a 5th write -> overflow pulses 1 cycle. Only the first 4 characters are transmitted.
6. Assert rst_n=0 mid-DATA of frame 1 with 2 entries queued -> tx=1 and tx_busy=0 immediately. FIFO is empty and nothing further is transmitted after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small TX FIFO, programmable bit time,
// optional even/odd parity and one or two stop bits.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tx_start,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              parity_en,
    input  logic                              even_parity,
    input  logic                              two_stop,
    output logic                              tx,
    output logic                              tx_busy,
    output logic                              fifo_full,
    output logic                              fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;

    logic [2:0]        r_state;
    logic [BW-1:0]     r_baud;
    logic [3:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bit;
    logic              r_par_en;
    logic              r_two_stop;
    logic              r_tx;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_end;
    logic              w_last_stop;
    logic [DATA_W-1:0] w_head;

    // Full uses the registered level, so a same-edge pop never frees room for a write
    assign w_full      = (r_level == LW'(FIFO_DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_push      = tx_start & ~w_full;
    assign w_baud_end  = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_last_stop = (r_state == S_STOP) & w_baud_end & (~r_two_stop | r_bit[0]);
    assign w_pop       = ~w_empty & ((r_state == S_IDLE) | w_last_stop);
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= tx_start & w_full;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_pop) begin
            // Pop from IDLE or straight out of the last stop bit (back-to-back frames)
            r_state    <= S_START;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= w_head;
            r_par_bit  <= (^w_head) ^ ~even_parity;
            r_par_en   <= parity_en;
            r_two_stop <= two_stop;
            r_tx       <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (!w_baud_end) begin
                r_baud <= r_baud + BW'(1);
            end else begin
                r_baud <= '0;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bit == 4'(DATA_W - 1)) begin
                            r_bit <= '0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                    end
                    S_STOP: begin
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx         = r_tx;
    assign tx_busy    = (r_state != S_IDLE);
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a separate
// monitor decodes the serial line and compares against them.
module tb_uart_tx_fifo;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int FD  = 4;
    localparam int LW  = $clog2(FD + 1);

    logic          clk;
    logic          rst_n;
    logic          tx_start;
    logic [DW-1:0] data_in;
    logic          parity_en;
    logic          even_parity;
    logic          two_stop;
    logic          tx;
    logic          tx_busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    uart_tx_fifo #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start),
        .data_in     (data_in),
        .parity_en   (parity_en),
        .even_parity (even_parity),
        .two_stop    (two_stop),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int unsigned len;
        logic [DW-1:0] data;
    } frame_t;

    frame_t        exp_q[$];
    int unsigned   vectors    = 0;
    int unsigned   miscompares = 0;
    int unsigned   run_len    = 0;
    int unsigned   last_run   = 0;
    logic [DW-1:0] bdata [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s)
    function automatic frame_t make_frame(input logic [DW-1:0] d, input bit pe, input bit ev, input bit ts);
        frame_t f;
        int unsigned n;
        bit par;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) f.bits[1 + i] = d[i];
        n = 1 + DW;
        if (pe) begin
            par = ($countones(d) % 2) == 1;
            if (!ev) par = !par;
            f.bits[n] = par;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (ts) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len  = n;
        f.data = d;
        return f;
    endfunction

    always @(negedge clk) begin
        if (tx_busy) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    // Monitor: decodes each frame on the line and compares with the scoreboard
    initial begin
        frame_t f;
        logic [15:0] got;
        bit b2b;
        bit ok;
        int w;
        b2b = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                b2b = 0;
                continue;
            end
            if (!b2b) begin
                w = 0;
                while (tx !== 1'b0 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check("start_bit_seen", {31'd0, tx}, 32'd0);
            end
            f   = exp_q.pop_front();
            got = '1;
            ok  = 1;
            for (int i = 0; i < int'(f.len); i++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    if (c == 0) got[i] = tx;
                    else if (tx !== got[i]) ok = 0;
                    if (tx_busy !== 1'b1) ok = 0;
                end
            end
            check($sformatf("frame_bits_0x%02h", f.data), {16'd0, got}, {16'd0, f.bits});
            check($sformatf("frame_stable_busy_0x%02h", f.data), {31'd0, ok}, 32'd1);
            b2b = (exp_q.size() > 0);
        end
    end

    task automatic write(input logic [DW-1:0] d, input bit sb);
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        data_in  = d;
        if (sb) exp_q.push_back(make_frame(d, parity_en, even_parity, two_stop));
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic burst(input int n, input bit sb, output int peak);
        peak = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            tx_start = 1'b1;
            data_in  = bdata[i];
            if (sb) exp_q.push_back(make_frame(bdata[i], parity_en, even_parity, two_stop));
            @(posedge clk);
            #1;
        end
        tx_start = 1'b0;
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    endtask

    task automatic wait_idle(input int limit);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((tx_busy || exp_q.size() > 0 || !fifo_empty) && w < limit);
        check("idle_reached", {31'd0, w < limit}, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int errs;
        int peak;
        int n;
        int unsigned exp_run;
        rst_n       = 1'b0;
        tx_start    = 1'b0;
        data_in     = '0;
        parity_en   = 1'b0;
        even_parity = 1'b0;
        two_stop    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_level", {29'd0, fifo_level}, 32'd0);
        rst_n = 1'b1;

        // Idle after reset
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b1 ||
                fifo_level !== '0 || fifo_full !== 1'b0) errs++;
        end
        check("idle_50_cycles", errs, 0);

        // Even parity, one stop bit, with pop latency
        parity_en = 1'b1; even_parity = 1'b1; two_stop = 1'b0;
        write(8'hA5, 1);
        @(negedge clk);
        check("latency_tx_high_after_write", {31'd0, tx}, 32'd1);
        check("latency_busy_low_after_write", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        check("latency_tx_low_next_edge", {31'd0, tx}, 32'd0);
        wait_idle(200);
        check("frame_len_even_1stop", last_run, 44);

        // Odd parity, two stop bits
        even_parity = 1'b0; two_stop = 1'b1;
        write(8'hA5, 1);
        wait_idle(200);
        check("frame_len_odd_2stop", last_run, 48);

        // Three consecutive writes, back-to-back frames
        parity_en = 1'b0; two_stop = 1'b0;
        bdata[0] = 8'h31; bdata[1] = 8'h32; bdata[2] = 8'h33;
        burst(3, 1, peak);
        check("level_peak", peak, 2);
        wait_idle(400);
        check("b2b_busy_run", last_run, 120);

        // Overflow: fill FIFO while busy, fifth write dropped
        write(8'h40, 1);
        repeat (3) @(posedge clk);
        bdata[0] = 8'h41; bdata[1] = 8'h42; bdata[2] = 8'h43; bdata[3] = 8'h44;
        burst(4, 1, peak);
        check("full_after_fill", {31'd0, fifo_full}, 32'd1);
        check("level_after_fill", {29'd0, fifo_level}, 32'd4);
        check("no_overflow_before", {31'd0, overflow}, 32'd0);
        write(8'h45, 0);
        check("overflow_pulse", {31'd0, overflow}, 32'd1);
        @(posedge clk);
        #1;
        check("overflow_one_cycle", {31'd0, overflow}, 32'd0);
        wait_idle(600);
        check("overflow_busy_run", last_run, 200);

        // Async reset mid-frame with entries queued
        bdata[0] = 8'h5A; bdata[1] = 8'h6B; bdata[2] = 8'h7C;
        burst(3, 0, peak);
        repeat (10) @(posedge clk);
        #2;
        check("level_before_reset", {29'd0, fifo_level}, 32'd2);
        check("busy_before_reset", {31'd0, tx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, tx_busy}, 32'd0);
        check("midreset_level", {29'd0, fifo_level}, 32'd0);
        check("midreset_empty", {31'd0, fifo_empty}, 32'd1);
        check("midreset_full", {31'd0, fifo_full}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b1) errs++;
        end
        check("quiet_after_reset", errs, 0);

        // Randomised rounds
        for (int r = 0; r < 20; r++) begin
            parity_en   = 1'($urandom_range(0, 1));
            even_parity = 1'($urandom_range(0, 1));
            two_stop    = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) bdata[i] = DW'($urandom);
            exp_run = n * (1 + DW + parity_en + 1 + two_stop) * CPB;
            burst(n, 1, peak);
            if (n == 1) begin
                // Config changes after the pop must not alter the frame in flight
                repeat (5) @(posedge clk);
                #1;
                parity_en   = ~parity_en;
                even_parity = 1'($urandom_range(0, 1));
                two_stop    = ~two_stop;
            end
            wait_idle(1000);
            check($sformatf("random_busy_run_%0d", r), last_run, exp_run);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
